// File: rtl/game_pkg.sv
// Shared encodings and screen constants for the Dino VGA design; the colour logic
// and key decoder import the same package.
package game_pkg;

   localparam int SCREEN_W     = 800;
   localparam int SCREEN_H     = 600;
   localparam int GROUND_Y_DEF = 520;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   typedef enum logic [1:0] {
      PH_GROUND = 2'd0,
      PH_UP     = 2'd1,
      PH_DOWN   = 2'd2
   } jump_phase_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Frame-rate event inputs and registered sprite/score outputs of the game sequencer.
interface game_sequencer_if;

   logic        frame_tick;
   logic        jump_req;
   logic        collision;
   logic [9:0]  dino_ver_from;
   logic [10:0] obst_hor_from;
   logic [15:0] score;
   logic [1:0]  game_state;
   logic        frame_update;

   modport master (
      output frame_tick, jump_req, collision,
      input  dino_ver_from, obst_hor_from, score, game_state, frame_update
   );

   modport slave (
      input  frame_tick, jump_req, collision,
      output dino_ver_from, obst_hor_from, score, game_state, frame_update
   );

endinterface

// File: rtl/game_sequencer_jump_ctrl.sv
// Dino jump phase FSM: rises JUMP_STEP lines per enabled frame to the apex, then falls
// back to ground. Requests while airborne are ignored because start only matters on ground.
module jump_ctrl
   import game_pkg::*;
#(
   parameter int GROUND_Y    = GROUND_Y_DEF,
   parameter int JUMP_HEIGHT = 160,
   parameter int JUMP_STEP   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       start,
   input  logic       restart,
   output logic [9:0] pos
);

   localparam logic [9:0] Y_GND = 10'(GROUND_Y);
   localparam logic [9:0] Y_TOP = 10'(GROUND_Y - JUMP_HEIGHT);
   localparam logic [9:0] DY    = 10'(JUMP_STEP);

   jump_phase_t phase, phase_nxt;
   logic [9:0]  pos_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= PH_GROUND;
         pos   <= Y_GND;
      end else begin
         phase <= phase_nxt;
         pos   <= pos_nxt;
      end
   end

   always_comb begin
      phase_nxt = phase;
      pos_nxt   = pos;
      if (restart) begin
         phase_nxt = PH_GROUND;
         pos_nxt   = Y_GND;
      end else if (step) begin
         unique case (phase)
            PH_GROUND: if (start) begin
               pos_nxt   = pos - DY;
               phase_nxt = (pos_nxt == Y_TOP) ? PH_DOWN : PH_UP;
            end
            PH_UP: begin
               pos_nxt = pos - DY;
               if (pos_nxt == Y_TOP) phase_nxt = PH_DOWN;
            end
            PH_DOWN: begin
               pos_nxt = pos + DY;
               if (pos_nxt == Y_GND) phase_nxt = PH_GROUND;
            end
            default: phase_nxt = PH_GROUND;
         endcase
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game controller: top FSM plus obstacle scroll, score and speed datapath.
// All state advances on frame_tick only, so sprite positions are stable during active video.
module game_sequencer
   import game_pkg::*;
#(
   parameter int GROUND_Y     = GROUND_Y_DEF,
   parameter int JUMP_HEIGHT  = 160,
   parameter int JUMP_STEP    = 8,
   parameter int OBST_START_X = SCREEN_W,
   parameter int SCROLL_STEP  = 4,
   parameter int MAX_STEP     = 12
) (
   input  logic           clk,
   input  logic           rst,
   game_sequencer_if.slave bus
);

   localparam logic [10:0] OBST_X   = 11'(OBST_START_X);
   localparam logic [3:0]  SPD_INIT = 4'(SCROLL_STEP);
   localparam logic [3:0]  SPD_MAX  = 4'(MAX_STEP);

   game_state_t state, state_nxt;
   logic        jump_pending, hit, frame_update_q;
   logic [10:0] obst, obst_nxt;
   logic [15:0] score_q, score_nxt;
   logic [3:0]  speed, speed_nxt;
   logic        step, restart, jp, hq;
   logic [9:0]  dino;

   // A pulse landing on the tick cycle counts toward that tick.
   assign jp = jump_pending | bus.jump_req;
   assign hq = hit | bus.collision;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      obst_nxt  = obst;
      score_nxt = score_q;
      speed_nxt = speed;
      step      = 1'b0;
      restart   = 1'b0;
      if (bus.frame_tick) begin
         unique case (state)
            ST_IDLE: if (jp) begin
               state_nxt = ST_RUN;
               step      = 1'b1;
            end
            ST_RUN: begin
               if (hq) state_nxt = ST_OVER;
               else    step      = 1'b1;
            end
            ST_OVER: if (jp) begin
               state_nxt = ST_RUN;
               restart   = 1'b1;
               obst_nxt  = OBST_X;
               score_nxt = '0;
               speed_nxt = SPD_INIT;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
      if (step) begin
         if (obst <= {7'd0, speed}) begin
            obst_nxt = OBST_X;
            if (score_q != 16'hFFFF) begin
               score_nxt = score_q + 16'd1;
               if (score_nxt[2:0] == 3'd0 && speed < SPD_MAX) speed_nxt = speed + 4'd1;
            end
         end else begin
            obst_nxt = obst - {7'd0, speed};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         obst           <= OBST_X;
         score_q        <= '0;
         speed          <= SPD_INIT;
         jump_pending   <= 1'b0;
         hit            <= 1'b0;
         frame_update_q <= 1'b0;
      end else begin
         obst           <= obst_nxt;
         score_q        <= score_nxt;
         speed          <= speed_nxt;
         jump_pending   <= bus.frame_tick ? 1'b0 : jp;
         hit            <= bus.frame_tick ? 1'b0 : hq;
         frame_update_q <= bus.frame_tick;
      end
   end

   jump_ctrl #(
      .GROUND_Y   (GROUND_Y),
      .JUMP_HEIGHT(JUMP_HEIGHT),
      .JUMP_STEP  (JUMP_STEP)
   ) u_jump (
      .clk    (clk),
      .rst    (rst),
      .step   (step),
      .start  (jp),
      .restart(restart),
      .pos    (dino)
   );

   assign bus.dino_ver_from = dino;
   assign bus.obst_hor_from = obst;
   assign bus.score         = score_q;
   assign bus.game_state    = state;
   assign bus.frame_update  = frame_update_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed plus randomized bench for game_sequencer against a frame-level reference model.
module tb_game_sequencer;

   localparam int GY = 520, JH = 160, JS = 8, OX = 800, SS = 4, MS = 12;
   localparam int JUMP_FRAMES = 2 * JH / JS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   game_sequencer_if bus();

   game_sequencer #(
      .GROUND_Y(GY), .JUMP_HEIGHT(JH), .JUMP_STEP(JS),
      .OBST_START_X(OX), .SCROLL_STEP(SS), .MAX_STEP(MS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int compared = 0, mismatched = 0;
   // Model: state 0/1/2, jump as frames-since-takeoff (0 = grounded).
   int m_state, m_k, m_obst, m_score;
   bit m_pend, m_hit;

   function automatic int m_dino();
      int up;
      up = (m_k <= JUMP_FRAMES / 2) ? m_k : (JUMP_FRAMES - m_k);
      return GY - JS * up;
   endfunction

   function automatic int m_speed();
      int s;
      s = SS + m_score / 8;
      return (s > MS) ? MS : s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int fu);
      chk({tag, ".state"}, 32'(bus.game_state), m_state);
      chk({tag, ".dino"},  32'(bus.dino_ver_from), m_dino());
      chk({tag, ".obst"},  32'(bus.obst_hor_from), m_obst);
      chk({tag, ".score"}, 32'(bus.score), m_score);
      chk({tag, ".frame_update"}, 32'(bus.frame_update), fu);
   endtask

   task automatic model_reset();
      m_state = 0; m_k = 0; m_obst = OX; m_score = 0; m_pend = 0; m_hit = 0;
   endtask

   task automatic model_motion(input bit jp);
      int spd;
      spd = m_speed();
      if (m_k == 0) begin
         if (jp) m_k = 1;
      end else begin
         m_k++;
         if (m_k == JUMP_FRAMES) m_k = 0;
      end
      if (m_obst <= spd) begin
         m_obst = OX;
         if (m_score < 65535) m_score++;
      end else begin
         m_obst -= spd;
      end
   endtask

   task automatic model_tick(input bit jr, input bit col);
      bit jp, h;
      jp = m_pend || jr;
      h  = m_hit || col;
      m_pend = 0;
      m_hit  = 0;
      case (m_state)
         0: if (jp) begin m_state = 1; model_motion(1'b1); end
         1: if (h) m_state = 2; else model_motion(jp);
         default: if (jp) begin model_reset(); m_state = 1; end
      endcase
   endtask

   // All stimulus tasks start and end on a falling edge.
   task automatic tick(input bit jr = 0, input bit col = 0);
      bus.frame_tick = 1'b1; bus.jump_req = jr; bus.collision = col;
      @(posedge clk);
      model_tick(jr, col);
      @(negedge clk);
      bus.frame_tick = 1'b0; bus.jump_req = 1'b0; bus.collision = 1'b0;
      chk_all("tick", 1);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         chk_all("gap", 0);
      end
   endtask

   task automatic pulse(input bit jr, input bit col);
      bus.jump_req = jr; bus.collision = col;
      @(negedge clk);
      bus.jump_req = 1'b0; bus.collision = 1'b0;
      if (jr) m_pend = 1;
      if (col) m_hit = 1;
      chk_all("pulse", 0);
   endtask

   task automatic do_reset();
      bus.frame_tick = 1'b0; bus.jump_req = 1'b0; bus.collision = 1'b0;
      #1 rst = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst", 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int frozen_obst, frozen_dino;
      bus.frame_tick = 1'b0; bus.jump_req = 1'b0; bus.collision = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_all("reset", 0);
      rst = 1'b1;
      @(negedge clk);

      // Idle frames: nothing moves, frame_update still pulses.
      for (int i = 0; i < 3; i++) begin
         tick();
         gap(2);
      end
      pulse(1'b0, 1'b1);
      tick();
      chk("idle_collision_state", 32'(bus.game_state), 0);

      // Start and complete one jump; a request at frame 10 is discarded.
      pulse(1'b1, 1'b0);
      gap(1);
      tick();
      chk("jump_first", 32'(bus.dino_ver_from), 512);
      chk("run_state", 32'(bus.game_state), 1);
      for (int t = 2; t <= JUMP_FRAMES; t++) begin
         tick(t == 10, 1'b0);
         if (t == 20) chk("jump_apex", 32'(bus.dino_ver_from), 360);
      end
      chk("jump_land", 32'(bus.dino_ver_from), 520);

      // Run to score 8 and observe the speed bump.
      for (int i = 0; i < 3000 && m_score < 8; i++) tick();
      chk("score8", 32'(bus.score), 8);
      chk("score8_wrap", 32'(bus.obst_hor_from), 800);
      tick();
      chk("speed5", 32'(bus.obst_hor_from), 795);

      // Mid-frame collision freezes everything; a request restarts cleanly.
      pulse(1'b0, 1'b1);
      gap(3);
      tick();
      chk("over_state", 32'(bus.game_state), 2);
      frozen_obst = int'(bus.obst_hor_from);
      frozen_dino = int'(bus.dino_ver_from);
      tick();
      tick(1'b0, 1'b1);
      chk("over_frozen_obst", 32'(bus.obst_hor_from), frozen_obst);
      chk("over_frozen_dino", 32'(bus.dino_ver_from), frozen_dino);
      pulse(1'b1, 1'b0);
      tick();
      chk("restart_obst", 32'(bus.obst_hor_from), 800);
      chk("restart_dino", 32'(bus.dino_ver_from), 520);
      chk("restart_score", 32'(bus.score), 0);
      for (int t = 1; t < 200; t++) tick();
      chk("scroll_199", 32'(bus.obst_hor_from), 4);
      tick();
      chk("scroll_wrap", 32'(bus.obst_hor_from), 800);
      chk("scroll_score1", 32'(bus.score), 1);

      // Requests and collisions coinciding with the tick.
      tick(1'b1, 1'b1);
      chk("same_cycle_over", 32'(bus.game_state), 2);
      tick(1'b1, 1'b0);
      chk("same_cycle_restart_dino", 32'(bus.dino_ver_from), 520);
      tick(1'b1, 1'b0);
      chk("same_cycle_jump", 32'(bus.dino_ver_from), 512);
      tick(1'b0, 1'b1);
      chk("same_cycle_hit", 32'(bus.game_state), 2);
      tick(1'b1, 1'b0);

      // Reset at jump frame 7 with score 3; operation resumes afterwards.
      for (int i = 0; i < 1000 && m_score < 3; i++) tick();
      tick(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      chk("pre_rst_score", 32'(bus.score), 3);
      chk("pre_rst_dino", 32'(bus.dino_ver_from), 464);
      do_reset();
      tick();
      tick(1'b1, 1'b0);
      chk("post_rst_jump", 32'(bus.dino_ver_from), 512);
      chk("post_rst_state", 32'(bus.game_state), 1);

      // Randomized traffic including back-to-back ticks and occasional resets.
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2) do_reset();
         else if (r < 20) pulse($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
         else if (r < 28) gap($urandom_range(1, 3));
         else tick($urandom_range(0, 7) == 0, $urandom_range(0, 30) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
